pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline register between two processor stages, e.g. decode→execute or execute→memory.
- Carries a control bundle plus NUM_DATA data words.
- Adds a valid/ready handshake, stall back-pressure, flush-to-bubble and an optional skid entry so the upstream ready is registered.
- One instance per stage boundary replaces the fixed per-boundary latch registers.

Parameters:
- DATA_W, 32, width of each data word.
- NUM_DATA, 4, number of data words carried (e.g. Xrs, Xrt, Y, PC_Y).
- CTRL_W, 11, width of the control bundle (RegWrt, MemtoReg, PCtoReg, BranchN, BranchZ, Jump, JumpMem, memRead, memWrite, ALUop[1:0]).
- SKID, 1, 1 = 2-entry buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a valid bundle.
- in_ready  out  1  stage can accept this cycle.
- ctrl_in  in  CTRL_W  control bundle.
- data_in  in  NUM_DATA*DATA_W  packed data words; word k at bits [k*DATA_W +: DATA_W].
- flush  in  1  kill all held entries (branch/jump taken).
- out_valid  out  1  downstream bundle valid.
- out_ready  in  1  downstream accepts (low = stall).
- ctrl_out  out  CTRL_W  control bundle; forced to 0 whenever out_valid=0.
- data_out  out  NUM_DATA*DATA_W  data words of the head entry.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, occupancy=0, ctrl_out=0, data_out=0. in_ready=1 on the first cycle after reset. Reset overrides flush and all handshakes, including mid-stall.
- Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency: a bundle accepted at edge N is visible on out_valid/ctrl_out/data_out after edge N (1 cycle).
- Ordering: strictly FIFO; no bundle is dropped or duplicated except by flush or rst.
- Bubble: ctrl_out is all-zero whenever out_valid=0, so no write enables leak downstream. data_out holds its last value when empty.
- SKID=1 states:
  - EMPTY (occ 0): in_ready=1. Input transfer → MAIN.
  - MAIN (occ 1): in_ready=1.
    - Input and output together → MAIN; head replaced by the new bundle.
    - Input only → FULL; new bundle goes to the skid register.
    - Output only → EMPTY.
  - FULL (occ 2): in_ready=0.
    - Output transfer → MAIN; skid moves to head.
    - Otherwise hold.
  - in_ready is a registered function of state only (in_ready = occupancy<2); it has no combinational path from out_ready.
- SKID=0: single entry. in_ready = ~out_valid | out_ready (combinational). Simultaneous in/out transfer replaces the head.
- Flush: at the edge where flush=1, all entries are cleared. Next cycle out_valid=0, occupancy=0, ctrl_out=0. Any same-cycle input transfer is discarded (flush wins). in_ready=1 after a flush.
- Stall (out_ready=0 with out_valid=1): head, ctrl_out and data_out are held bit-stable. With SKID=1, exactly one more bundle is absorbed before in_ready drops.
- Widths: no arithmetic; all payload bits pass unmodified. Control and data are stored together per entry, never split across entries.

Test Plan:
- Reset/latency: assert rst for 2 cycles → out_valid=0, ctrl_out=0, occupancy=0, in_ready=1. Then present ctrl_in=11'h5A3, word0=32'hDEADBEEF for 1 cycle with out_ready=1 → next cycle out_valid=1, ctrl_out=11'h5A3, data_out word0=32'hDEADBEEF; following cycle out_valid=0, ctrl_out=0.
- Streaming: 8 back-to-back bundles (word0=0..7) with out_ready=1 → outputs 0..7 on consecutive cycles, occupancy stays 1, in_ready stays 1.
- Stall/skid (SKID=1): hold out_ready=0 while pushing A, B, C → A and B accepted, occupancy=2, in_ready=0, C held upstream. Release out_ready → outputs A, B, C in order, no loss or duplication.
- Flush: with occupancy=2, assert flush together with in_valid=1 (bundle D) → next cycle out_valid=0, ctrl_out=0, occupancy=0, D never appears at the output.
- Reset mid-stall: occupancy=2 with out_ready=0, pulse rst one cycle → all outputs return to reset values and subsequent traffic is clean.
- SKID=0 build: with out_ready=0 and out_valid=1 → in_ready=0 in the same cycle. Raise out_ready → in_ready=1 combinationally and the simultaneous transfer replaces the head.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Bundle port between two pipeline stages: upstream valid/ready/payload in,
// downstream valid/ready/payload out. The slave modport is the stage register's view.
interface pipe_stage_reg_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 4,
  parameter int CTRL_W   = 11
);
  logic                       in_valid;
  logic                       in_ready;
  logic [CTRL_W-1:0]          ctrl_in;
  logic [NUM_DATA*DATA_W-1:0] data_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [CTRL_W-1:0]          ctrl_out;
  logic [NUM_DATA*DATA_W-1:0] data_out;

  modport slave (
    input  in_valid, ctrl_in, data_in, out_ready,
    output in_ready, out_valid, ctrl_out, data_out
  );

  modport master (
    output in_valid, ctrl_in, data_in, out_ready,
    input  in_ready, out_valid, ctrl_out, data_out
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: control bundle plus NUM_DATA words, with stall,
// flush-to-bubble and an optional skid entry that makes in_ready registered.
module pipe_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 4,
  parameter int CTRL_W   = 11,
  parameter int SKID     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [1:0]       state_dbg
);
  localparam int PW = NUM_DATA * DATA_W;

  // Handshake: a bundle moves across a port on a rising edge exactly when
  // valid and ready are both high there; valid never depends on ready.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MAIN  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic [PW-1:0]     head_data, skid_data;
  logic              in_ready_q;
  logic              in_ready, out_valid;
  logic              in_xfer, out_xfer;
  logic              load_head, load_skid, pop_skid;

  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q : (~out_valid | bus.out_ready);
  assign in_xfer   = bus.in_valid & in_ready;
  assign out_xfer  = out_valid & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d   = S_MAIN;
            load_head = 1'b1;
          end
        end
        S_MAIN: begin
          if (in_xfer && out_xfer) begin
            load_head = 1'b1;
          end else if (in_xfer) begin
            // Without a skid entry in_xfer already implies out_xfer here.
            if (SKID != 0) begin
              state_d   = S_FULL;
              load_skid = 1'b1;
            end
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            state_d  = S_MAIN;
            pop_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      head_ctrl  <= '0;
      head_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_FULL);
      if (load_head) begin
        head_ctrl <= bus.ctrl_in;
        head_data <= bus.data_in;
      end else if (pop_skid) begin
        head_ctrl <= skid_ctrl;
        head_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= bus.ctrl_in;
        skid_data <= bus.data_in;
      end
    end
  end

  // Bubbles carry zero control so no write enable leaks downstream.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.ctrl_out  = out_valid ? head_ctrl : '0;
  assign bus.data_out  = head_data;
  assign occupancy     = state_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 instance and one SKID=0 instance.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int ND = 4;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush1 = 1'b0;
  logic flush0 = 1'b0;
  logic [1:0] occ1, occ0, st1, st0;
  int passed = 0;
  int total = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW)) b1 ();
  pipe_stage_reg_if #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW)) b0 ();

  pipe_stage_reg #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW), .SKID(1)) u_skid1 (
    .clk(clk), .rst(rst), .flush(flush1), .bus(b1), .occupancy(occ1), .state_dbg(st1)
  );
  pipe_stage_reg #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW), .SKID(0)) u_skid0 (
    .clk(clk), .rst(rst), .flush(flush0), .bus(b0), .occupancy(occ0), .state_dbg(st0)
  );

  function automatic logic [ND*DW-1:0] mk_data(input logic [DW-1:0] w);
    return {w + 32'd3, w + 32'd2, w + 32'd1, w};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] w);
    b1.in_valid = v;
    b1.ctrl_in  = c;
    b1.data_in  = mk_data(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (b1.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", b1.out_valid); else passed++;
    total++; if (b1.ctrl_out !== 11'h0) $display("FAIL rst_ctrl: got %h want 000", b1.ctrl_out); else passed++;
    total++; if (occ1 !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occ1); else passed++;
    total++; if (b1.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", b1.in_ready); else passed++;
    total++; if (b1.data_out !== '0) $display("FAIL rst_data: got %h want 0", b1.data_out); else passed++;
    total++; if (b0.out_valid !== 1'b0) $display("FAIL rst0_valid: got %b want 0", b0.out_valid); else passed++;
  endtask

  task automatic test_latency();
    b1.out_ready = 1'b1;
    drive1(1'b1, 11'h5A3, 32'hDEADBEEF);
    step();
    drive1(1'b0, 11'h000, 32'h0);
    total++; if (b1.out_valid !== 1'b1) $display("FAIL lat_valid: got %b want 1", b1.out_valid); else passed++;
    total++; if (b1.ctrl_out !== 11'h5A3) $display("FAIL lat_ctrl: got %h want 5a3", b1.ctrl_out); else passed++;
    total++; if (b1.data_out[0 +: DW] !== 32'hDEADBEEF) $display("FAIL lat_word0: got %h want deadbeef", b1.data_out[0 +: DW]); else passed++;
    total++; if (b1.data_out !== mk_data(32'hDEADBEEF)) $display("FAIL lat_data: got %h want %h", b1.data_out, mk_data(32'hDEADBEEF)); else passed++;
    step();
    total++; if (b1.out_valid !== 1'b0) $display("FAIL lat_bubble_valid: got %b want 0", b1.out_valid); else passed++;
    total++; if (b1.ctrl_out !== 11'h0) $display("FAIL lat_bubble_ctrl: got %h want 000", b1.ctrl_out); else passed++;
    total++; if (b1.data_out[0 +: DW] !== 32'hDEADBEEF) $display("FAIL lat_data_hold: got %h want deadbeef", b1.data_out[0 +: DW]); else passed++;
  endtask

  task automatic test_streaming();
    b1.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, CW'(11'h40 + i), DW'(i));
      step();
      total++; if (b1.out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, b1.out_valid); else passed++;
      total++; if (b1.data_out[0 +: DW] !== DW'(i)) $display("FAIL stream_word0[%0d]: got %h want %h", i, b1.data_out[0 +: DW], i); else passed++;
      total++; if (b1.ctrl_out !== CW'(11'h40 + i)) $display("FAIL stream_ctrl[%0d]: got %h want %h", i, b1.ctrl_out, 11'h40 + i); else passed++;
      total++; if (occ1 !== 2'd1) $display("FAIL stream_occ[%0d]: got %0d want 1", i, occ1); else passed++;
      total++; if (b1.in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, b1.in_ready); else passed++;
    end
    drive1(1'b0, 11'h0, 32'h0);
    step();
    total++; if (occ1 !== 2'd0) $display("FAIL stream_drain_occ: got %0d want 0", occ1); else passed++;
  endtask

  task automatic test_stall_skid();
    logic acc;
    exp_q.delete();
    exp_q.push_back(32'hA0A0_0001);
    exp_q.push_back(32'hB0B0_0002);
    exp_q.push_back(32'hC0C0_0003);
    b1.out_ready = 1'b0;
    drive1(1'b1, 11'h1A1, 32'hA0A0_0001);
    step();
    total++; if (occ1 !== 2'd1 || b1.in_ready !== 1'b1) $display("FAIL stall_a: got occ %0d rdy %b want occ 1 rdy 1", occ1, b1.in_ready); else passed++;
    drive1(1'b1, 11'h1B2, 32'hB0B0_0002);
    step();
    total++; if (occ1 !== 2'd2 || b1.in_ready !== 1'b0) $display("FAIL stall_b: got occ %0d rdy %b want occ 2 rdy 0", occ1, b1.in_ready); else passed++;
    drive1(1'b1, 11'h1C3, 32'hC0C0_0003);
    step();
    total++; if (occ1 !== 2'd2 || b1.in_ready !== 1'b0) $display("FAIL stall_c_held: got occ %0d rdy %b want occ 2 rdy 0", occ1, b1.in_ready); else passed++;
    total++; if (b1.data_out[0 +: DW] !== 32'hA0A0_0001 || b1.ctrl_out !== 11'h1A1) $display("FAIL stall_head_stable: got %h/%h want a0a00001/1a1", b1.data_out[0 +: DW], b1.ctrl_out); else passed++;
    b1.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (b1.out_valid) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL stall_extra: got %h want nothing", b1.data_out[0 +: DW]);
        else if (b1.data_out[0 +: DW] !== exp_q[0]) begin
          $display("FAIL stall_order: got %h want %h", b1.data_out[0 +: DW], exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          passed++;
          void'(exp_q.pop_front());
        end
      end
      acc = b1.in_valid & b1.in_ready;
      step();
      if (acc) drive1(1'b0, 11'h0, 32'h0);
    end
    total++; if (exp_q.size() != 0) $display("FAIL stall_lost: got %0d left want 0", exp_q.size()); else passed++;
    total++; if (occ1 !== 2'd0) $display("FAIL stall_drain_occ: got %0d want 0", occ1); else passed++;
  endtask

  task automatic test_flush();
    b1.out_ready = 1'b0;
    drive1(1'b1, 11'h2A1, 32'h1111_0001);
    step();
    drive1(1'b1, 11'h2B2, 32'h1111_0002);
    step();
    total++; if (occ1 !== 2'd2) $display("FAIL flush_pre_occ: got %0d want 2", occ1); else passed++;
    flush1 = 1'b1;
    drive1(1'b1, 11'h2DD, 32'hDDDD_DDDD);
    step();
    flush1 = 1'b0;
    drive1(1'b0, 11'h0, 32'h0);
    total++; if (b1.out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", b1.out_valid); else passed++;
    total++; if (b1.ctrl_out !== 11'h0) $display("FAIL flush_ctrl: got %h want 000", b1.ctrl_out); else passed++;
    total++; if (occ1 !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occ1); else passed++;
    total++; if (b1.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", b1.in_ready); else passed++;
    b1.out_ready = 1'b1;
    step();
    step();
    total++; if (b1.out_valid !== 1'b0) $display("FAIL flush_d_leak: got %b want 0", b1.out_valid); else passed++;
    drive1(1'b1, 11'h2E5, 32'hEEEE_0005);
    step();
    drive1(1'b1, 11'h2F6, 32'hFFFF_0006);
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    drive1(1'b0, 11'h0, 32'h0);
    total++; if (occ1 !== 2'd0 || b1.out_valid !== 1'b0) $display("FAIL flush_wins_input: got occ %0d valid %b want 0/0", occ1, b1.out_valid); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    b1.out_ready = 1'b0;
    drive1(1'b1, 11'h3A1, 32'h3333_0001);
    step();
    drive1(1'b1, 11'h3B2, 32'h3333_0002);
    step();
    total++; if (occ1 !== 2'd2) $display("FAIL rstmid_pre_occ: got %0d want 2", occ1); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive1(1'b0, 11'h0, 32'h0);
    total++; if (b1.out_valid !== 1'b0 || occ1 !== 2'd0) $display("FAIL rstmid_state: got valid %b occ %0d want 0/0", b1.out_valid, occ1); else passed++;
    total++; if (b1.ctrl_out !== 11'h0 || b1.data_out !== '0) $display("FAIL rstmid_payload: got %h/%h want 0/0", b1.ctrl_out, b1.data_out); else passed++;
    total++; if (b1.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", b1.in_ready); else passed++;
    b1.out_ready = 1'b1;
    drive1(1'b1, 11'h3C3, 32'h3333_0003);
    step();
    drive1(1'b0, 11'h0, 32'h0);
    total++; if (b1.out_valid !== 1'b1 || b1.data_out !== mk_data(32'h3333_0003)) $display("FAIL rstmid_traffic: got %b/%h want 1/%h", b1.out_valid, b1.data_out, mk_data(32'h3333_0003)); else passed++;
    step();
    total++; if (b1.out_valid !== 1'b0) $display("FAIL rstmid_drain: got %b want 0", b1.out_valid); else passed++;
  endtask

  task automatic test_skid0();
    b0.out_ready = 1'b0;
    b0.in_valid  = 1'b1;
    b0.ctrl_in   = 11'h4A1;
    b0.data_in   = mk_data(32'h4444_0001);
    step();
    total++; if (b0.out_valid !== 1'b1 || occ0 !== 2'd1) $display("FAIL s0_load: got valid %b occ %0d want 1/1", b0.out_valid, occ0); else passed++;
    b0.ctrl_in = 11'h4B2;
    b0.data_in = mk_data(32'h4444_0002);
    #1;
    total++; if (b0.in_ready !== 1'b0) $display("FAIL s0_stall_ready: got %b want 0", b0.in_ready); else passed++;
    step();
    total++; if (b0.data_out[0 +: DW] !== 32'h4444_0001 || b0.ctrl_out !== 11'h4A1 || occ0 !== 2'd1) $display("FAIL s0_stall_hold: got %h/%h occ %0d want 44440001/4a1 occ 1", b0.data_out[0 +: DW], b0.ctrl_out, occ0); else passed++;
    b0.out_ready = 1'b1;
    #1;
    total++; if (b0.in_ready !== 1'b1) $display("FAIL s0_comb_ready: got %b want 1", b0.in_ready); else passed++;
    step();
    b0.in_valid = 1'b0;
    total++; if (b0.data_out !== mk_data(32'h4444_0002) || b0.ctrl_out !== 11'h4B2 || occ0 !== 2'd1) $display("FAIL s0_replace: got %h/%h occ %0d want %h/4b2 occ 1", b0.data_out, b0.ctrl_out, occ0, mk_data(32'h4444_0002)); else passed++;
    step();
    total++; if (b0.out_valid !== 1'b0 || b0.ctrl_out !== 11'h0) $display("FAIL s0_drain: got %b/%h want 0/000", b0.out_valid, b0.ctrl_out); else passed++;
  endtask

  initial begin
    drive1(1'b0, 11'h0, 32'h0);
    b1.out_ready = 1'b1;
    b0.in_valid  = 1'b0;
    b0.ctrl_in   = 11'h0;
    b0.data_in   = '0;
    b0.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_reset_mid_stall();
    test_skid0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
